// File: rtl/fp_addsub_result.sv
// Result stage after the FP add/sub datapath: IEEE-754 single special-case
// overrides, exception flags, a 2-entry writeback FIFO and sticky FFLAGS.
module fp_addsub_result #(
   parameter int unsigned RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     op_a,
   input  logic [31:0]     op_b,
   input  logic            in_sub,
   input  logic [31:0]     raw_result,
   input  logic [RD_W-1:0] in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_data,
   output logic [RD_W-1:0] out_rd,
   output logic [4:0]      out_flags,
   output logic [4:0]      fflags,
   input  logic            fflags_we,
   input  logic [4:0]      fflags_wdata
);
   localparam int unsigned DEPTH  = 2;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned FLAG_W = 5;
   localparam logic [31:0] QNAN   = 32'h7FC0_0000;

   logic [31:0]       data_q  [DEPTH];
   logic [RD_W-1:0]   rd_q    [DEPTH];
   logic [FLAG_W-1:0] flags_q [DEPTH];
   logic              wptr;
   logic              rptr;
   logic [CNT_W-1:0]  count;

   logic              sb;
   logic              a_nan, b_nan, a_snan, b_snan;
   logic              a_inf, b_inf, a_zero, b_zero;
   logic              push, pop;
   logic [31:0]       res_c;
   logic [FLAG_W-1:0] flg_c;

   // Operand classification; denormals count as zero.
   assign sb     = op_b[31] ^ in_sub;
   assign a_nan  = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
   assign b_nan  = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);
   assign a_snan = a_nan && !op_a[22];
   assign b_snan = b_nan && !op_b[22];
   assign a_inf  = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
   assign b_inf  = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
   assign a_zero = (op_a[30:23] == 8'h00);
   assign b_zero = (op_b[30:23] == 8'h00);

   // Priority-ordered result override; flags are {NV,DZ,OF,UF,NX}.
   always_comb begin
      res_c = raw_result;
      flg_c = '0;
      if (a_nan || b_nan) begin
         res_c    = QNAN;
         flg_c[4] = a_snan || b_snan;
      end else if (a_inf && b_inf && (op_a[31] != sb)) begin
         res_c    = QNAN;
         flg_c[4] = 1'b1;
      end else if (a_inf) begin
         res_c = op_a;
      end else if (b_inf) begin
         res_c = {sb, op_b[30:0]};
      end else if (a_zero && b_zero) begin
         res_c = {op_a[31] & sb, 31'd0};
      end else if (a_zero) begin
         res_c = {sb, op_b[30:0]};
      end else if (b_zero) begin
         res_c = op_a;
      end else if ((op_a[30:0] == op_b[30:0]) && (op_a[31] != sb)) begin
         res_c = 32'd0;
      end else if (raw_result[30:23] == 8'hFF) begin
         res_c    = {raw_result[31], 8'hFF, 23'd0};
         flg_c[2] = 1'b1;
         flg_c[0] = 1'b1;
      end else if ((raw_result[30:23] == 8'h00) && (raw_result[22:0] != 23'd0)) begin
         res_c    = {raw_result[31], 31'd0};
         flg_c[1] = 1'b1;
         flg_c[0] = 1'b1;
      end
   end

   assign in_ready  = rst & (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = data_q[rptr];
   assign out_rd    = rd_q[rptr];
   assign out_flags = flags_q[rptr];
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // FIFO storage, pointers, occupancy and sticky flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i]  <= '0;
            rd_q[i]    <= '0;
            flags_q[i] <= '0;
         end
         wptr   <= 1'b0;
         rptr   <= 1'b0;
         count  <= '0;
         fflags <= '0;
      end else begin
         if (push) begin
            data_q[wptr]  <= res_c;
            rd_q[wptr]    <= in_rd;
            flags_q[wptr] <= flg_c;
            wptr          <= ~wptr;
         end
         if (pop) begin
            rptr <= ~rptr;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         // A CSR write takes precedence over retirement accumulation.
         if (fflags_we) begin
            fflags <= fflags_wdata;
         end else if (pop) begin
            fflags <= fflags | out_flags;
         end
      end
   end
endmodule

// File: tb/tb_fp_addsub_result.sv
// Randomised and directed bench for fp_addsub_result against a queue-based
// reference model of the override rules, FIFO and sticky flags.
module tb_fp_addsub_result;
   localparam int unsigned RD_W = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [31:0]     op_a = '0;
   logic [31:0]     op_b = '0;
   logic            in_sub = 1'b0;
   logic [31:0]     raw_result = '0;
   logic [RD_W-1:0] in_rd = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [31:0]     out_data;
   logic [RD_W-1:0] out_rd;
   logic [4:0]      out_flags;
   logic [4:0]      fflags;
   logic            fflags_we = 1'b0;
   logic [4:0]      fflags_wdata = '0;

   fp_addsub_result #(.RD_W(RD_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .in_sub(in_sub), .raw_result(raw_result),
      .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_rd(out_rd), .out_flags(out_flags),
      .fflags(fflags), .fflags_we(fflags_we), .fflags_wdata(fflags_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  rd;
      logic [4:0]  f;
   } exp_t;

   exp_t       exp_q[$];
   logic [4:0] m_ff;
   int         errors = 0;
   int         checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, want);
      end
   endtask

   function automatic logic is_nan(input logic [31:0] x);
      return x[30:23] == 8'hFF && x[22:0] != 0;
   endfunction
   function automatic logic is_snan(input logic [31:0] x);
      return is_nan(x) && x[22] == 1'b0;
   endfunction
   function automatic logic is_inf(input logic [31:0] x);
      return x[30:23] == 8'hFF && x[22:0] == 0;
   endfunction
   function automatic logic is_zero(input logic [31:0] x);
      return x[30:23] == 8'h00;
   endfunction

   // Reference: first matching rule decides the result and flags.
   function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic [31:0] raw, input logic [4:0] rd);
      exp_t e;
      logic s_b;
      s_b  = b[31] ^ sub;
      e.rd = rd;
      e.f  = 5'b00000;
      if (is_nan(a) || is_nan(b)) begin
         e.d = 32'h7FC00000;
         if (is_snan(a) || is_snan(b)) e.f = 5'b10000;
      end else if (is_inf(a) && is_inf(b) && a[31] != s_b) begin
         e.d = 32'h7FC00000; e.f = 5'b10000;
      end else if (is_inf(a))                     e.d = a;
      else if (is_inf(b))                         e.d = {s_b, b[30:0]};
      else if (is_zero(a) && is_zero(b))          e.d = {a[31] & s_b, 31'd0};
      else if (is_zero(a))                        e.d = {s_b, b[30:0]};
      else if (is_zero(b))                        e.d = a;
      else if (a[30:0] == b[30:0] && a[31] != s_b) e.d = 32'd0;
      else if (raw[30:23] == 8'hFF) begin
         e.d = {raw[31], 8'hFF, 23'd0}; e.f = 5'b00101;
      end else if (raw[30:23] == 8'h00 && raw[22:0] != 0) begin
         e.d = {raw[31], 31'd0}; e.f = 5'b00011;
      end else                                    e.d = raw;
      return e;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ":in_ready"}, 32'(in_ready), 32'(exp_q.size() < 2));
      check({tag, ":out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check({tag, ":out_data"}, out_data, exp_q[0].d);
         check({tag, ":out_rd"}, 32'(out_rd), 32'(exp_q[0].rd));
         check({tag, ":out_flags"}, 32'(out_flags), 32'(exp_q[0].f));
      end
      check({tag, ":fflags"}, 32'(fflags), 32'(m_ff));
   endtask

   // Called at a negedge: apply inputs, advance the model, clock, re-check.
   task automatic drive(input string tag, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic sub, input logic [31:0] raw,
                        input logic [4:0] rd, input logic ordy, input logic we,
                        input logic [4:0] wd);
      logic do_push, do_pop;
      exp_t e;
      in_valid = v; op_a = a; op_b = b; in_sub = sub; raw_result = raw;
      in_rd = rd; out_ready = ordy; fflags_we = we; fflags_wdata = wd;
      do_pop  = exp_q.size() > 0 && ordy;
      do_push = v && exp_q.size() < 2;
      e = ref_op(a, b, sub, raw, rd);
      if (we) m_ff = wd;
      else if (do_pop) m_ff = m_ff | exp_q[0].f;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input logic [31:0] raw, input logic [4:0] rd);
      drive(tag, 1'b1, a, b, sub, raw, rd, 1'b1, 1'b0, 5'd0);
   endtask

   task automatic idle(input string tag, input logic ordy, input logic we, input logic [4:0] wd);
      drive(tag, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, ordy, we, wd);
   endtask

   function automatic logic [31:0] rand_fp();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 7))
         0: return {r[31], 8'h00, 23'd0};
         1: return {r[31], 8'hFF, 23'd0};
         2: return {r[31], 8'hFF, 1'b1, r[21:0]};
         3: return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
         4: return {r[31], 8'h00, r[22:1], 1'b1};
         default: return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
      endcase
   endfunction

   function automatic logic [31:0] rand_raw();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: return {r[31], 8'hFF, 23'd0};
         1: return {r[31], 8'h00, r[22:1], 1'b1};
         default: return r;
      endcase
   endfunction

   initial begin
      logic [31:0] a, b;
      m_ff = 5'd0;
      repeat (2) @(negedge clk);
      check("rst:out_valid", 32'(out_valid), 32'd0);
      check("rst:out_data", out_data, 32'd0);
      check("rst:out_rd", 32'(out_rd), 32'd0);
      check("rst:out_flags", 32'(out_flags), 32'd0);
      check("rst:fflags", 32'(fflags), 32'd0);
      check("rst:in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1 check_all("release");

      // Directed result cases
      op("add", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'd3);
      check("add_data", out_data, 32'h40400000);
      check("add_rd", 32'(out_rd), 32'd3);
      check("add_flags", 32'(out_flags), 32'h00);
      op("infinf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h12345678, 5'd4);
      check("infinf_data", out_data, 32'h7FC00000);
      check("infinf_flags", 32'(out_flags), 32'h10);
      op("snan", 32'h7F800001, 32'h3F800000, 1'b0, 32'h3F800000, 5'd5);
      check("snan_data", out_data, 32'h7FC00000);
      check("snan_flags", 32'(out_flags), 32'h10);
      op("qnan", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h3F800000, 5'd6);
      check("qnan_data", out_data, 32'h7FC00000);
      check("qnan_flags", 32'(out_flags), 32'h00);
      op("negzero", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 5'd7);
      check("negzero_data", out_data, 32'h80000000);
      op("cancel", 32'h3F800000, 32'h3F800000, 1'b1, 32'h3F800000, 5'd8);
      check("cancel_data", out_data, 32'h00000000);
      op("ovf", 32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 5'd9);
      check("ovf_data", out_data, 32'h7F800000);
      check("ovf_flags", 32'(out_flags), 32'h05);

      // Sticky flag accumulation and CSR override
      idle("clr", 1'b1, 1'b1, 5'd0);
      op("nv_op", 32'h7F800000, 32'hFF800000, 1'b0, 32'h0, 5'd10);
      op("of_op", 32'h7E000000, 32'h7E800000, 1'b0, 32'hFF800000, 5'd11);
      idle("retire", 1'b1, 1'b0, 5'd0);
      check("fflags_acc", 32'(fflags), 32'h15);
      op("uf_op", 32'h3F800000, 32'h40000000, 1'b0, 32'h00000001, 5'd12);
      check("uf_flags", 32'(out_flags), 32'h03);
      idle("csr_win", 1'b1, 1'b1, 5'd0);
      check("fflags_csr", 32'(fflags), 32'h00);

      // Backpressure with three back-to-back requests
      drive("bp1", 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'd1, 1'b0, 1'b0, 5'd0);
      drive("bp2", 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'd2, 1'b0, 1'b0, 5'd0);
      check("bp_full", 32'(in_ready), 32'd0);
      drive("bp3w", 1'b1, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 5'd3, 1'b0, 1'b0, 5'd0);
      check("bp_stable", out_data, 32'h40000000);
      drive("bp3a", 1'b1, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 5'd3, 1'b1, 1'b0, 5'd0);
      check("bp_order2", out_data, 32'h40400000);
      drive("bp3b", 1'b1, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 5'd3, 1'b1, 1'b0, 5'd0);
      check("bp_order3", out_data, 32'h40800000);
      idle("bp_drain", 1'b1, 1'b0, 5'd0);

      // Asynchronous reset with a full FIFO and nonzero flags
      drive("pre_rst1", 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'd1, 1'b0, 1'b1, 5'h1F);
      drive("pre_rst2", 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'd2, 1'b0, 1'b0, 5'd0);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_fflags", 32'(fflags), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd0);
      exp_q.delete();
      m_ff = 5'd0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_rst_ready", 32'(in_ready), 32'd1);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      idle("post_rst", 1'b1, 1'b0, 5'd0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         a = rand_fp();
         b = ($urandom_range(0, 5) == 0) ? {$urandom_range(0, 1) == 1, a[30:0]} : rand_fp();
         drive("rand", $urandom_range(0, 3) != 0, a, b, 1'($urandom_range(0, 1)), rand_raw(),
               5'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, 5'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
